// File: rtl/adder_req_sched_pkg.sv
// Shared types and constants for the adder request scheduler.
// Holds the FSM state encoding, default sizes and the stats counter width.
package adder_req_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 2;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/adder.sv
// Shared registered adder: f is a+b (mod 2^WIDTH), one cycle after a/b.
// Ports: m_clock, p_reset (async, active-low), a, b in; f out.
module adder
    import adder_req_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_d;

    always_comb begin
        f_d = a + b;
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            f_q <= '0;
        end else begin
            f_q <= f_d;
        end
    end

    assign f = f_q;

endmodule

// File: rtl/adder_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or above pointer, with wrap.
// Ports: req, pointer, enable in; one-hot gnt, winner index, any out.
module rr_arbiter
    import adder_req_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    always_comb begin
        int idx;
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(pointer) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (enable && !any && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = IDW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_req_sched.sv
// Shares one registered adder among NREQ requesters with round-robin arbitration.
// Ports: m_clock, p_reset (async, active-low); req/req_a/req_b from clients,
// gnt one-hot pulse back; add_a/add_b/add_f to the adder; rsp_valid/ready/id/data out.
// Macro ADDER_REQ_SCHED_STATS_EN adds op_count (saturating accepted responses) and busy.
module adder_req_sched
    import adder_req_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  m_clock,
    input  logic                  p_reset,
`ifdef ADDER_REQ_SCHED_STATS_EN
    output logic [CNT_W-1:0]      op_count,
    output logic                  busy,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_f,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data
);

    state_e           state_q;
    state_e           state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   id_d;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] op_b_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_win;
    logic             arb_any;
    logic             arb_en;
    logic             op_live;

    // Gating with p_reset keeps gnt low while reset is held,
    // even if clients keep their requests up.
    assign arb_en = (state_q == IDLE) && p_reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req),
        .pointer (ptr_q),
        .enable  (arb_en),
        .gnt     (arb_gnt),
        .winner  (arb_win),
        .any     (arb_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    op_a_d  = req_a[arb_win*WIDTH +: WIDTH];
                    op_b_d  = req_b[arb_win*WIDTH +: WIDTH];
                    id_d    = arb_win;
                    // Winner drops to lowest priority next round.
                    ptr_d   = (arb_win == IDW'(NREQ - 1)) ? '0
                                                          : arb_win + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    // Operands stay on the adder through RESULT so add_f is stable
    // for as long as the response is held.
    assign op_live   = (state_q == ISSUE) || (state_q == RESULT);
    assign gnt       = arb_gnt;
    assign add_a     = op_live ? op_a_q : '0;
    assign add_b     = op_live ? op_b_q : '0;
    assign rsp_valid = (state_q == RESULT);
    assign rsp_id    = rsp_valid ? id_q : '0;
    assign rsp_data  = rsp_valid ? add_f : '0;

`ifdef ADDER_REQ_SCHED_STATS_EN
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid && rsp_ready && (op_count_q != '1)) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
    assign busy     = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_adder_req_sched.sv
// Scoreboard bench for adder_req_sched driving the real adder.
// Directed phases then randomized traffic against a transaction-level model.
module tb_adder_req_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 2;
    localparam int IDW   = 2;

    logic                  m_clock = 1'b0;
    logic                  p_reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_f;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
`ifdef ADDER_REQ_SCHED_STATS_EN
    logic [15:0]           op_count;
    logic                  busy;
`endif

    adder_req_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
`ifdef ADDER_REQ_SCHED_STATS_EN
        .op_count  (op_count),
        .busy      (busy),
`endif
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_f     (add_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .a       (add_a),
        .b       (add_b),
        .f       (add_f)
    );

    always #5 m_clock = ~m_clock;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t            exp_q[$];
    int              checks = 0;
    int              errors = 0;
    logic [NREQ-1:0] granted = '0;
    int              m_ptr = 0;
    bit              m_busy = 1'b0;
    int              m_age = 0;
    int              cyc = 0;
    int              accepted = 0;
    int              gnt_win[$];
    int              gnt_cyc[$];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Transaction-level reference: one operation in flight at a time,
    // response due two cycles after grant and held until accepted.
    always @(negedge m_clock) begin
        logic [NREQ-1:0] eg;
        int w;
        int a;
        int b;
        cyc++;
        if (!p_reset) begin
            m_ptr    = 0;
            m_busy   = 1'b0;
            m_age    = 0;
            accepted = 0;
            granted  = '0;
        end else begin
            if (m_busy) m_age++;
            chk("rsp_valid", int'(rsp_valid), int'(m_busy && m_age >= 2));
            eg = '0;
            w  = 0;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (req[i] && eg == '0) begin
                        eg[i] = 1'b1;
                        w     = i;
                    end
                end
                chk("add_idle", int'({add_a, add_b}), 0);
            end
            chk("gnt", int'(gnt), int'(eg));
`ifdef ADDER_REQ_SCHED_STATS_EN
            chk("busy", int'(busy), int'(m_busy));
`endif
            granted = eg;
            if (eg != '0) begin
                a = int'(req_a[w*WIDTH +: WIDTH]);
                b = int'(req_b[w*WIDTH +: WIDTH]);
                exp_q.push_back('{w, (a + b) % (1 << WIDTH)});
                m_ptr  = (w + 1) % NREQ;
                m_busy = 1'b1;
                m_age  = 0;
                gnt_win.push_back(w);
                gnt_cyc.push_back(cyc);
            end else if (m_busy && m_age >= 2 && rsp_ready) begin
                m_busy = 1'b0;
                accepted++;
            end
        end
    end

    // Monitor: pops on every accepted response; checks hold under backpressure.
    bit       pv = 1'b0;
    int       pid = 0;
    int       pdata = 0;
    exp_t     e;

    always @(negedge m_clock) begin
        if (!p_reset) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_id", int'(rsp_id), pid);
                chk("hold_data", int'(rsp_data), pdata);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d data %0d expected none",
                             rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_data", int'(rsp_data), e.data);
                end
            end
            pv    = rsp_valid && !rsp_ready;
            pid   = int'(rsp_id);
            pdata = int'(rsp_data);
        end
    end

    task automatic step();
        @(posedge m_clock);
        #1;
    endtask

    task automatic set_ops(int id, int a, int b);
        req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    // Returns at the cycle after the capturing edge (scheduler in ISSUE).
    task automatic issue_one(int id, int a, int b);
        bit ok;
        ok = 1'b0;
        req[id] = 1'b1;
        set_ops(id, a, b);
        for (int t = 0; t < 40; t++) begin
            step();
            if (granted[id]) begin
                ok = 1'b1;
                break;
            end
        end
        req[id] = 1'b0;
        chk("grant_timeout", int'(ok), 1);
    endtask

    task automatic idle_drain();
        req       = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 8; t++) step();
    endtask

    task automatic do_reset();
        p_reset = 1'b0;
        exp_q.delete();
        step();
        step();
        p_reset = 1'b1;
    endtask

    initial begin
        int n;
        bit seen;
        p_reset = 1'b0;
        step();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_add_a", int'(add_a), 0);
        chk("rst_add_b", int'(add_b), 0);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_id", int'(rsp_id), 0);
        chk("rst_data", int'(rsp_data), 0);
        step();
        p_reset = 1'b1;
        step();

        issue_one(1, 1, 2);
        idle_drain();
        issue_one(0, 3, 2);
        idle_drain();

        do_reset();
        gnt_win.delete();
        gnt_cyc.delete();
        req = '1;
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i]) begin
                    set_ops(i, $urandom_range(0, 3), $urandom_range(0, 3));
                end
            end
            step();
        end
        req = '0;
        chk("rr_count", int'(gnt_win.size() >= 5), 1);
        if (gnt_win.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("rr_order", gnt_win[k], k % NREQ);
                if (k > 0) chk("rr_spacing", gnt_cyc[k] - gnt_cyc[k-1], 3);
            end
        end
        idle_drain();

        rsp_ready = 1'b0;
        issue_one(2, 3, 3);
        req[0] = 1'b1;
        set_ops(0, 2, 1);
        for (int t = 0; t < 6; t++) step();
        rsp_ready = 1'b1;
        n    = 0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            n++;
            if (granted[0]) begin
                seen = 1'b1;
                break;
            end
        end
        req[0] = 1'b0;
        chk("bp_regrant", int'(seen), 1);
        chk("bp_regrant_cycles", n, 2);
        idle_drain();

        issue_one(1, 2, 3);
        p_reset = 1'b0;
        #1;
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_valid", int'(rsp_valid), 0);
        chk("midrst_add", int'({add_a, add_b}), 0);
        exp_q.delete();
        req = 4'b1001;
        set_ops(0, 1, 1);
        set_ops(3, 2, 2);
        step();
        chk("midrst_gnt_held", int'(gnt), 0);
        step();
        p_reset = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (granted != '0) begin
                seen = 1'b1;
                chk("postrst_first", int'(granted), 1);
                break;
            end
        end
        chk("postrst_seen", int'(seen), 1);
        req[0] = 1'b0;
        idle_drain();

        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    set_ops(i, $urandom_range(0, 3), $urandom_range(0, 3));
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        set_ops(i, $urandom_range(0, 3), $urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_drain();
        chk("queue_empty", exp_q.size(), 0);
`ifdef ADDER_REQ_SCHED_STATS_EN
        chk("op_count", int'(op_count), accepted);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
